// File: rtl/sc_entryfrogger_pkg.sv
// Shared state and load-code encodings for the frogger entry-row control FSM.
// Optional COOLDOWN behaviour is selected by ENTRYFROGGER_COOLDOWN_EN in sc_entryfrogger_ctrl.
package sc_entryfrogger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHOW_RIGHT = 3'd1,
        ST_SHOW_LEFT  = 3'd2,
        ST_COOLDOWN   = 3'd3,
        ST_CLEAR      = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RIGHT = 2'b01;
    localparam logic [1:0] CODE_LEFT  = 2'b10;
    localparam logic [1:0] CODE_CLEAR = 2'b11;

    function automatic logic [1:0] code_of(input state_t s);
        logic [1:0] code;
        code = CODE_NONE;
        case (s)
            ST_SHOW_RIGHT: code = CODE_RIGHT;
            ST_SHOW_LEFT:  code = CODE_LEFT;
            ST_CLEAR:      code = CODE_CLEAR;
            default:       code = CODE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sc_entryfrogger_edgedet.sv
// Falling-edge detector for an active-low debounced button; the history flop
// resets to the released level so a button held through reset does fire once.
module sc_entryfrogger_edgedet (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= btn;
        end
    end

    assign press = prev & ~btn;

endmodule

// File: rtl/sc_entryfrogger_ctrl.sv
// Entry-row load-code FSM: turns left/right presses and clear into timed codes.
// Define ENTRYFROGGER_COOLDOWN_EN to insert a forced-NONE COOLDOWN after each hold.
//
// Handshake: there is none; press inputs are level samples, and every output
// (code, move pulses, busy) is a registered function of the next state.
module sc_entryfrogger_ctrl
    import sc_entryfrogger_pkg::*;
#(
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int COOLDOWN_CYCLES = 12_500_000,
    parameter int CNT_WIDTH       = 25
) (
    input  logic       SC_ENTRYFROGGER_CLOCK_50,
    input  logic       SC_ENTRYFROGGER_RESET_InHigh,
    input  logic       SC_ENTRYFROGGER_left_InLow,
    input  logic       SC_ENTRYFROGGER_right_InLow,
    input  logic       SC_ENTRYFROGGER_clear_InHigh,
    output logic [1:0] SC_ENTRYFROGGER_loadEntry_OutBUS,
    output logic       SC_ENTRYFROGGER_moveLeft_OutHigh,
    output logic       SC_ENTRYFROGGER_moveRight_OutHigh,
    output logic       SC_ENTRYFROGGER_busy_OutHigh,
    output logic [2:0] dbg_state
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
`ifdef ENTRYFROGGER_COOLDOWN_EN
    localparam logic [CNT_WIDTH-1:0] COOL_LOAD = CNT_WIDTH'(COOLDOWN_CYCLES - 1);
`endif

    logic                 clk;
    logic                 rst;
    logic                 press_l;
    logic                 press_r;
    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 next_ml;
    logic                 next_mr;
    logic                 start_ok;

    assign clk = SC_ENTRYFROGGER_CLOCK_50;
    assign rst = SC_ENTRYFROGGER_RESET_InHigh;

    sc_entryfrogger_edgedet u_edge_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (SC_ENTRYFROGGER_left_InLow),
        .press (press_l)
    );

    sc_entryfrogger_edgedet u_edge_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (SC_ENTRYFROGGER_right_InLow),
        .press (press_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                             <= ST_IDLE;
            cnt                               <= '0;
            SC_ENTRYFROGGER_loadEntry_OutBUS  <= CODE_NONE;
            SC_ENTRYFROGGER_moveLeft_OutHigh  <= 1'b0;
            SC_ENTRYFROGGER_moveRight_OutHigh <= 1'b0;
            SC_ENTRYFROGGER_busy_OutHigh      <= 1'b0;
        end else begin
            state                             <= next_state;
            cnt                               <= next_cnt;
            SC_ENTRYFROGGER_loadEntry_OutBUS  <= code_of(next_state);
            SC_ENTRYFROGGER_moveLeft_OutHigh  <= next_ml;
            SC_ENTRYFROGGER_moveRight_OutHigh <= next_mr;
            SC_ENTRYFROGGER_busy_OutHigh      <= (next_state != ST_IDLE);
        end
    end

    // The last cycle of a hold/cooldown behaves like IDLE so a press landing
    // exactly when the sequence ends is accepted without a dead cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_ml    = 1'b0;
        next_mr    = 1'b0;
        start_ok   = 1'b0;
        if (SC_ENTRYFROGGER_clear_InHigh) begin
            next_state = ST_CLEAR;
            next_cnt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    start_ok = 1'b1;
                end
                ST_SHOW_RIGHT, ST_SHOW_LEFT: begin
                    if (cnt == '0) begin
`ifdef ENTRYFROGGER_COOLDOWN_EN
                        next_state = ST_COOLDOWN;
                        next_cnt   = COOL_LOAD;
`else
                        next_state = ST_IDLE;
                        start_ok   = 1'b1;
`endif
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt == '0) begin
                        next_state = ST_IDLE;
                        start_ok   = 1'b1;
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end
                default: begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end
            endcase

            if (start_ok && press_r && !press_l) begin
                next_state = ST_SHOW_RIGHT;
                next_cnt   = HOLD_LOAD;
                next_mr    = 1'b1;
            end else if (start_ok && press_l && !press_r) begin
                next_state = ST_SHOW_LEFT;
                next_cnt   = HOLD_LOAD;
                next_ml    = 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sc_entryfrogger_ctrl.sv
// Self-checking bench for sc_entryfrogger_ctrl: directed scenarios followed by
// random button/clear traffic, all checked against a sequence-level model.
module tb_sc_entryfrogger_ctrl;
    import sc_entryfrogger_pkg::*;

    localparam int H = 4;
`ifdef ENTRYFROGGER_COOLDOWN_EN
    localparam int C = 3;
`else
    localparam int C = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_n = 1'b1;
    logic       right_n = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] load_entry;
    logic       move_left;
    logic       move_right;
    logic       busy;
    logic [2:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a hold is described by its start edge and direction.
    int         edge_n;
    int         m_start;
    logic       m_active;
    logic       m_dir_right;
    logic       m_clear;
    logic       m_prev_l;
    logic       m_prev_r;
    logic [1:0] exp_code;
    logic       exp_ml;
    logic       exp_mr;
    logic       exp_busy;

    sc_entryfrogger_ctrl #(
        .HOLD_CYCLES     (H),
        .COOLDOWN_CYCLES (3),
        .CNT_WIDTH       (3)
    ) dut (
        .SC_ENTRYFROGGER_CLOCK_50          (clk),
        .SC_ENTRYFROGGER_RESET_InHigh      (rst),
        .SC_ENTRYFROGGER_left_InLow        (left_n),
        .SC_ENTRYFROGGER_right_InLow       (right_n),
        .SC_ENTRYFROGGER_clear_InHigh      (clr),
        .SC_ENTRYFROGGER_loadEntry_OutBUS  (load_entry),
        .SC_ENTRYFROGGER_moveLeft_OutHigh  (move_left),
        .SC_ENTRYFROGGER_moveRight_OutHigh (move_right),
        .SC_ENTRYFROGGER_busy_OutHigh      (busy),
        .dbg_state                         (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active    = 1'b0;
        m_clear     = 1'b0;
        m_start     = 0;
        m_dir_right = 1'b0;
        m_prev_l    = 1'b1;
        m_prev_r    = 1'b1;
        exp_code    = 2'b00;
        exp_ml      = 1'b0;
        exp_mr      = 1'b0;
        exp_busy    = 1'b0;
    endtask

    task automatic model_edge(input logic l, input logic r, input logic c);
        logic pl;
        logic pr;
        logic idle;
        pl     = m_prev_l & ~l;
        pr     = m_prev_r & ~r;
        exp_ml = 1'b0;
        exp_mr = 1'b0;
        if (c) begin
            exp_code = 2'b11;
            exp_busy = 1'b1;
            m_clear  = 1'b1;
            m_active = 1'b0;
        end else if (m_clear) begin
            exp_code = 2'b00;
            exp_busy = 1'b0;
            m_clear  = 1'b0;
        end else begin
            idle = !m_active || (edge_n - m_start >= H + C);
            if (idle && (pl ^ pr)) begin
                m_active    = 1'b1;
                m_start     = edge_n;
                m_dir_right = pr;
                exp_code    = pr ? 2'b01 : 2'b10;
                exp_busy    = 1'b1;
                exp_mr      = pr;
                exp_ml      = pl;
            end else if (idle) begin
                m_active = 1'b0;
                exp_code = 2'b00;
                exp_busy = 1'b0;
            end else begin
                exp_code = (edge_n - m_start < H) ? (m_dir_right ? 2'b01 : 2'b10) : 2'b00;
                exp_busy = 1'b1;
            end
        end
        m_prev_l = l;
        m_prev_r = r;
        edge_n++;
    endtask

    task automatic check_all(input string tag);
        vectors++;
        assert (load_entry === exp_code) else begin
            miscompares++;
            $error("FAIL %s load_entry observed=%0b expected=%0b t=%0t", tag, load_entry, exp_code, $time);
        end
        vectors++;
        assert (move_left === exp_ml) else begin
            miscompares++;
            $error("FAIL %s move_left observed=%0b expected=%0b t=%0t", tag, move_left, exp_ml, $time);
        end
        vectors++;
        assert (move_right === exp_mr) else begin
            miscompares++;
            $error("FAIL %s move_right observed=%0b expected=%0b t=%0t", tag, move_right, exp_mr, $time);
        end
        vectors++;
        assert (busy === exp_busy) else begin
            miscompares++;
            $error("FAIL %s busy observed=%0b expected=%0b t=%0t", tag, busy, exp_busy, $time);
        end
        vectors++;
        assert ((dbg_state != ST_IDLE) === exp_busy) else begin
            miscompares++;
            $error("FAIL %s state_idle observed=%0d expected_busy=%0b t=%0t", tag, dbg_state, exp_busy, $time);
        end
    endtask

    task automatic step(input logic l, input logic r, input logic c, input string tag);
        left_n  = l;
        right_n = r;
        clr     = c;
        @(posedge clk);
        model_edge(l, r, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        int pulses;
        logic rl;
        logic rr;
        logic rc;
        edge_n = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, "idle");

        // single right press and its full hold/cooldown sequence
        step(1'b1, 1'b0, 1'b0, "right_press");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "right_seq");

        // left held low: exactly one move pulse
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b0, "left_held");
            if (move_left) pulses++;
        end
        vectors++;
        assert (pulses === 1) else begin
            miscompares++;
            $error("FAIL left_held_pulses observed=%0d expected=1", pulses);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "release");

        // simultaneous presses are discarded
        step(1'b0, 1'b0, 1'b0, "both_press");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "both_after");

        // right press during SHOW_LEFT is ignored
        step(1'b0, 1'b1, 1'b0, "left_press");
        step(1'b0, 1'b0, 1'b0, "right_in_show");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "left_seq");

        // clear mid SHOW_RIGHT for 5 cycles
        step(1'b1, 1'b0, 1'b0, "right_press2");
        step(1'b1, 1'b1, 1'b0, "right_hold2");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, "clear_on");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "clear_off");

        // clear in the same cycle as a press wins
        step(1'b0, 1'b1, 1'b1, "clear_with_press");
        step(1'b1, 1'b1, 1'b0, "clear_drop");

        // back-to-back presses at the earliest accepted edge
        step(1'b1, 1'b0, 1'b0, "b2b_first");
        for (int i = 0; i < H + C - 1; i++) step(1'b1, 1'b1, 1'b0, "b2b_wait");
        step(1'b0, 1'b1, 1'b0, "b2b_second");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, "b2b_tail");

        // asynchronous reset mid-hold
        step(1'b1, 1'b0, 1'b0, "pre_reset_press");
        step(1'b1, 1'b1, 1'b0, "pre_reset_hold");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "post_reset");

        // random traffic
        rl = 1'b1;
        rr = 1'b1;
        rc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) rl = ~rl;
            if ($urandom_range(0, 5) == 0) rr = ~rr;
            if (rc) rc = ($urandom_range(0, 3) != 0);
            else    rc = ($urandom_range(0, 39) == 0);
            step(rl, rr, rc, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
